// File: rtl/boolean_resp_checker.sv
// Response analyzer for exhaustive boolean stimulus: samples a 1-bit DUT response once its
// input vector has settled, checks it against a truth table and flags pass/fail/timeout.
module boolean_resp_checker #(
    parameter int unsigned         N_IN    = 3,
    parameter logic [2**N_IN-1:0]  EXP_TT  = 8'hEA,
    parameter int unsigned         SETTLE  = 2,
    parameter int unsigned         TIMEOUT = 1024,
    parameter int unsigned         ERR_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N_IN-1:0]      vec_in,
    input  logic                 resp,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [ERR_W-1:0]     err_cnt,
    output logic                 first_err_vld,
    output logic [N_IN-1:0]      first_err_vec,
    output logic [2**N_IN-1:0]   seen_mask
);

    localparam int unsigned NVec  = 2**N_IN;
    localparam int unsigned StabW = $clog2(SETTLE + 2);
    localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

    localparam logic [StabW-1:0] StabOne    = StabW'(1);
    localparam logic [StabW-1:0] StabSample = StabW'(SETTLE);
    localparam logic [TmoW-1:0]  TmoLimit   = TmoW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [StabW-1:0]  stab_q, stab_d, stab_nxt;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              fvld_q, fvld_d;
    logic [N_IN-1:0]   fvec_q, fvec_d;
    logic [NVec-1:0]   seen_q, seen_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              tflag_q, tflag_d;
    logic              sample;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        stab_d   = stab_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        fvld_d   = fvld_q;
        fvec_d   = fvec_q;
        seen_d   = seen_q;
        done_d   = done_q;
        pass_d   = pass_q;
        tflag_d  = tflag_q;
        stab_nxt = stab_q;
        sample   = 1'b0;

        if (start) begin
            // The vector present during start counts as freshly applied.
            state_d = StRun;
            vec_d   = vec_in;
            stab_d  = StabOne;
            tmo_d   = '0;
            err_d   = '0;
            fvld_d  = 1'b0;
            fvec_d  = '0;
            seen_d  = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            tflag_d = 1'b0;
        end else if (state_q == StRun) begin
            // Count saturates one past SETTLE so a held vector is sampled only once.
            if (vec_in != vec_q) begin
                stab_nxt = StabOne;
            end else if (stab_q > StabSample) begin
                stab_nxt = stab_q;
            end else begin
                stab_nxt = stab_q + 1'b1;
            end
            vec_d  = vec_in;
            stab_d = stab_nxt;
            sample = (stab_nxt == StabSample);

            if (sample) begin
                tmo_d          = '0;
                seen_d[vec_in] = 1'b1;
                if (resp != EXP_TT[vec_in]) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fvld_q) begin
                        fvld_d = 1'b1;
                        fvec_d = vec_in;
                    end
                end
                if (&seen_d) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end
            end else begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_d >= TmoLimit) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                    tflag_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vec_q   <= '0;
            stab_q  <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
            fvld_q  <= 1'b0;
            fvec_q  <= '0;
            seen_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            stab_q  <= stab_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            fvld_q  <= fvld_d;
            fvec_q  <= fvec_d;
            seen_q  <= seen_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tflag_q <= tflag_d;
        end
    end

    assign busy          = (state_q == StRun);
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = tflag_q;
    assign err_cnt       = err_q;
    assign first_err_vld = fvld_q;
    assign first_err_vec = fvec_q;
    assign seen_mask     = seen_q;

endmodule

// File: tb/tb_boolean_resp_checker.sv
// Directed bench for boolean_resp_checker: a behavioural d = (a&b)|c DUT with injectable
// faults drives the checker through sweeps, short holds, timeout, saturation and resets.
module tb_boolean_resp_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] vec = 3'd0;
    logic       resp;
    logic       busy, done, pass, timeout, first_err_vld;
    logic [7:0] err_cnt, seen_mask;
    logic [2:0] first_err_vec;

    logic       bad_en  = 1'b0;
    logic [2:0] bad_vec = 3'd0;
    logic       inv_all = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Model DUT; faults flip its output.
    always_comb begin
        resp = ((vec[2] & vec[1]) | vec[0]) ^ (inv_all | (bad_en && (vec == bad_vec)));
    end

    boolean_resp_checker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .vec_in        (vec),
        .resp          (resp),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_cnt       (err_cnt),
        .first_err_vld (first_err_vld),
        .first_err_vec (first_err_vec),
        .seen_mask     (seen_mask)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic apply(input logic [2:0] v, input int n);
        vec = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sweep();
        for (int v = 0; v < 8; v++) apply(3'(v), 10);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_pass"}, pass, 0);
        check_eq({tag, "_tmo"}, timeout, 0);
        check_eq({tag, "_err"}, err_cnt, 0);
        check_eq({tag, "_fvld"}, first_err_vld, 0);
        check_eq({tag, "_fvec"}, first_err_vec, 0);
        check_eq({tag, "_seen"}, seen_mask, 0);
    endtask

    initial begin
        int waited;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean sweep.
        vec = 3'd0;
        pulse_start();
        check_eq("t1_busy", busy, 1);
        sweep();
        check_eq("t1_done", done, 1);
        check_eq("t1_pass", pass, 1);
        check_eq("t1_err", err_cnt, 0);
        check_eq("t1_seen", seen_mask, 8'hFF);
        check_eq("t1_tmo", timeout, 0);
        check_eq("t1_busy_end", busy, 0);

        // Wrong response at vector 5.
        bad_en = 1'b1; bad_vec = 3'd5;
        vec = 3'd0;
        pulse_start();
        check_eq("t2_cleared", done, 0);
        sweep();
        check_eq("t2_done", done, 1);
        check_eq("t2_pass", pass, 0);
        check_eq("t2_err", err_cnt, 1);
        check_eq("t2_fvld", first_err_vld, 1);
        check_eq("t2_fvec", first_err_vec, 5);

        // Short holds: 0 and 1 held one cycle, 2 held two, 3 wrong and held long.
        bad_vec = 3'd3;
        vec = 3'd0;
        pulse_start();
        apply(3'd1, 1);
        apply(3'd2, 2);
        apply(3'd3, 20);
        check_eq("t3_seen", seen_mask, 8'h0C);
        check_eq("t3_err", err_cnt, 1);
        check_eq("t3_fvec", first_err_vec, 3);
        check_eq("t3_busy", busy, 1);
        bad_en = 1'b0;

        // Vector 7 never applied: expect timeout.
        vec = 3'd0;
        pulse_start();
        for (int v = 0; v < 7; v++) apply(3'(v), 10);
        repeat (900) @(posedge clk);
        #1;
        check_eq("t4_no_early_tmo", timeout, 0);
        waited = 0;
        while (!done && waited < 400) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check_eq("t4_wait_bounded", (waited < 400), 1);
        check_eq("t4_tmo", timeout, 1);
        check_eq("t4_done", done, 1);
        check_eq("t4_pass", pass, 0);
        check_eq("t4_seen", seen_mask, 8'h7F);

        // 300 mismatching samples alternating between vectors 0 and 1.
        inv_all = 1'b1;
        vec = 3'd1;
        pulse_start();
        for (int i = 0; i < 300; i++) apply(3'(i % 2), 2);
        check_eq("t5_err_sat", err_cnt, 8'hFF);
        check_eq("t5_seen", seen_mask, 8'h03);
        check_eq("t5_fvec", first_err_vec, 0);
        check_eq("t5_busy", busy, 1);
        inv_all = 1'b0;

        // Asynchronous reset mid-run, then a clean rerun.
        vec = 3'd0;
        pulse_start();
        for (int v = 0; v < 4; v++) apply(3'(v), 10);
        rst_n = 1'b0;
        #2;
        check_all_zero("t6_rst");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        vec = 3'd0;
        pulse_start();
        sweep();
        check_eq("t6_done", done, 1);
        check_eq("t6_pass", pass, 1);

        // Start from DONE clears and reruns.
        bad_en = 1'b1; bad_vec = 3'd2;
        vec = 3'd0;
        pulse_start();
        check_eq("t7_done_clr", done, 0);
        check_eq("t7_seen_clr", seen_mask, 0);
        check_eq("t7_busy", busy, 1);
        sweep();
        check_eq("t7_pass", pass, 0);
        check_eq("t7_fvec", first_err_vec, 2);
        check_eq("t7_err", err_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
